// File: rtl/csr_unit_ms.sv
// RV32 CSR unit with M/S/U privilege: two-stage registered CSR access with forwarding,
// exception/interrupt delegation, prioritised interrupts and direct/vectored trap entry.
module csr_unit_ms #(
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter int unsigned HART_ID     = 0,
    parameter bit          SUPPORT_S   = 1'b1,
    parameter bit          VECTORED    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] reg_cycle,
    input  logic [63:0] reg_time,
    input  logic [63:0] reg_mtime,
    input  logic [63:0] reg_mtimecmp,
    input  logic        irq_ext,
    input  logic        irq_soft,
    input  logic        wb_branch_hazard,
    input  logic        input_valid,
    input  logic [2:0]  input_csr_cmd,
    input  logic [11:0] input_csr_addr,
    input  logic [31:0] input_op1_data,
    input  logic [31:0] input_pc,
    input  logic        input_interrupt_ready,
    output logic        output_valid,
    output logic [31:0] csr_rdata,
    output logic        trap_valid,
    output logic [31:0] trap_vector,
    output logic [1:0]  output_mode,
    output logic        output_stall_flg_may_interrupt
);

    localparam logic [2:0] CSR_X = 3'd0, CSR_W = 3'd1, CSR_S = 3'd2, CSR_C = 3'd3;
    localparam logic [2:0] CSR_ECALL = 3'd4, CSR_MRET = 3'd5, CSR_SRET = 3'd6;
    localparam logic [1:0] PRIV_U = 2'd0, PRIV_S = 2'd1, PRIV_M = 2'd3;

    localparam logic [31:0] MSTATUS_WMASK = SUPPORT_S ? 32'h0002_19AA : 32'h0002_1888;
    localparam logic [31:0] SSTATUS_MASK  = SUPPORT_S ? 32'h0000_0122 : 32'h0;
    localparam logic [31:0] S_IRQ_BITS    = SUPPORT_S ? 32'h0000_0222 : 32'h0;
    localparam logic [31:0] MIE_WMASK     = SUPPORT_S ? 32'h0000_0AAA : 32'h0000_0888;
    // ECALL from M (cause 11) can never be delegated
    localparam logic [31:0] MEDELEG_WMASK = SUPPORT_S ? 32'h0000_F7FF : 32'h0;
    localparam logic [31:0] MISA_VAL      = 32'h4010_0100 | (SUPPORT_S ? 32'h0004_0000 : 32'h0);

    logic [1:0]  mode_q, mode_d;
    logic [31:0] mstatus_q, mstatus_d, medeleg_q, medeleg_d, mideleg_q, mideleg_d;
    logic [31:0] mie_q, mie_d, sw_ip_q, sw_ip_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [31:0] stvec_q, stvec_d, sscratch_q, sscratch_d, sepc_q, sepc_d;
    logic [31:0] scause_q, scause_d, stval_q, stval_d;

    logic        b_valid_q;
    logic [2:0]  b_cmd_q;
    logic [11:0] b_addr_q;
    logic [31:0] b_op1_q, b_pc_q, rdata_q;
    logic        out_valid_q, trap_valid_q;
    logic [31:0] trap_vector_q;

    logic        accept, csr_we, trap_take, enter, enter_s, is_int;
    logic [31:0] wdata, trap_vec, tvec, epc, rd, mip_cur, mip_next;
    logic [3:0]  code, int_cause;
    logic [11:0] pend, int_en;
    logic        m_en, s_en, int_any, mtip;

    function automatic logic [31:0] legal_tvec(input logic [31:0] w);
        logic [31:0] r;
        r = w & ~32'h3;
        if (w[1:0] == 2'b01 && VECTORED) r[0] = 1'b1;
        return r;
    endfunction

    assign accept  = input_valid && !wb_branch_hazard;
    assign mtip    = reg_mtime >= reg_mtimecmp;
    assign mip_cur = {20'b0, irq_ext, 3'b0, mtip, 3'b0, irq_soft, 3'b0} | sw_ip_q;
    assign mip_next = {20'b0, irq_ext, 3'b0, mtip, 3'b0, irq_soft, 3'b0} | sw_ip_d;

    // Interrupt enable per target level, then fixed priority MEI>MSI>MTI>SEI>SSI>STI
    always_comb begin
        m_en   = (mode_q != PRIV_M) || mstatus_q[3];
        s_en   = (mode_q == PRIV_U) || (mode_q == PRIV_S && mstatus_q[1]);
        pend   = mip_cur[11:0] & mie_q[11:0];
        int_en = (pend & ~mideleg_q[11:0] & {12{m_en}}) | (pend & mideleg_q[11:0] & {12{s_en}});
        int_any = |int_en;
        int_cause = 4'd0;
        if (int_en[11])     int_cause = 4'd11;
        else if (int_en[3]) int_cause = 4'd3;
        else if (int_en[7]) int_cause = 4'd7;
        else if (int_en[9]) int_cause = 4'd9;
        else if (int_en[1]) int_cause = 4'd1;
        else if (int_en[5]) int_cause = 4'd5;
    end

    assign output_stall_flg_may_interrupt = int_any;

    always_comb begin
        mode_d = mode_q;       mstatus_d = mstatus_q;   medeleg_d = medeleg_q;
        mideleg_d = mideleg_q; mie_d = mie_q;           sw_ip_d = sw_ip_q;
        mtvec_d = mtvec_q;     mscratch_d = mscratch_q; mepc_d = mepc_q;
        mcause_d = mcause_q;   mtval_d = mtval_q;       stvec_d = stvec_q;
        sscratch_d = sscratch_q; sepc_d = sepc_q;       scause_d = scause_q;
        stval_d = stval_q;
        trap_take = 1'b0;
        trap_vec  = '0;
        enter     = 1'b0;
        enter_s   = 1'b0;
        is_int    = 1'b0;
        code      = '0;
        epc       = '0;
        tvec      = '0;

        wdata = b_op1_q;
        if (b_cmd_q == CSR_S)      wdata = rdata_q | b_op1_q;
        else if (b_cmd_q == CSR_C) wdata = rdata_q & ~b_op1_q;

        csr_we = b_valid_q && (b_cmd_q == CSR_W || b_cmd_q == CSR_S || b_cmd_q == CSR_C)
                 && b_addr_q[11:10] != 2'b11 && (SUPPORT_S || b_addr_q[9:8] != 2'b01);

        if (csr_we) begin
            case (b_addr_q)
                12'h300: begin
                    mstatus_d = (mstatus_q & ~MSTATUS_WMASK) | (wdata & MSTATUS_WMASK);
                    if (wdata[12:11] == 2'b10 || (!SUPPORT_S && wdata[12:11] == 2'b01))
                        mstatus_d[12:11] = mstatus_q[12:11];
                end
                12'h302: medeleg_d  = wdata & MEDELEG_WMASK;
                12'h303: mideleg_d  = wdata & S_IRQ_BITS;
                12'h304: mie_d      = wdata & MIE_WMASK;
                12'h305: mtvec_d    = legal_tvec(wdata);
                12'h340: mscratch_d = wdata;
                12'h341: mepc_d     = wdata & ~32'h3;
                12'h342: mcause_d   = wdata;
                12'h343: mtval_d    = wdata;
                12'h344: sw_ip_d    = wdata & S_IRQ_BITS;
                12'h100: mstatus_d  = (mstatus_q & ~SSTATUS_MASK) | (wdata & SSTATUS_MASK);
                12'h104: mie_d      = (mie_q & ~mideleg_q) | (wdata & mideleg_q & MIE_WMASK);
                12'h105: stvec_d    = legal_tvec(wdata);
                12'h140: sscratch_d = wdata;
                12'h141: sepc_d     = wdata & ~32'h3;
                12'h142: scause_d   = wdata;
                12'h143: stval_d    = wdata;
                12'h144: sw_ip_d    = (sw_ip_q & ~(mideleg_q & 32'h2)) | (wdata & mideleg_q & 32'h2);
                default: ;
            endcase
        end

        // A stage-B ECALL/xRET blocks interrupt entry until the next cycle
        if (b_valid_q && b_cmd_q == CSR_ECALL) begin
            enter   = 1'b1;
            code    = 4'd8 + {2'b0, mode_q};
            enter_s = SUPPORT_S && mode_q != PRIV_M && medeleg_q[code];
            epc     = b_pc_q;
        end else if (b_valid_q && b_cmd_q == CSR_MRET) begin
            if (mode_q == PRIV_M) begin
                trap_take         = 1'b1;
                trap_vec          = mepc_q;
                mode_d            = mstatus_q[12:11];
                mstatus_d[3]      = mstatus_q[7];
                mstatus_d[7]      = 1'b1;
                mstatus_d[12:11]  = PRIV_U;
                if (mstatus_q[12:11] != PRIV_M) mstatus_d[17] = 1'b0;
            end
        end else if (b_valid_q && b_cmd_q == CSR_SRET) begin
            if (SUPPORT_S && mode_q != PRIV_U) begin
                trap_take    = 1'b1;
                trap_vec     = sepc_q;
                mode_d       = {1'b0, mstatus_q[8]};
                mstatus_d[1] = mstatus_q[5];
                mstatus_d[5] = 1'b1;
                mstatus_d[8] = 1'b0;
            end
        end else if (!b_valid_q && int_any && input_interrupt_ready) begin
            enter   = 1'b1;
            is_int  = 1'b1;
            code    = int_cause;
            enter_s = mideleg_q[int_cause];
            epc     = input_pc;
        end

        if (enter) begin
            trap_take = 1'b1;
            if (enter_s) begin
                tvec         = stvec_q;
                sepc_d       = epc & ~32'h3;
                scause_d     = {is_int, 27'b0, code};
                stval_d      = '0;
                mstatus_d[5] = mstatus_q[1];
                mstatus_d[1] = 1'b0;
                mstatus_d[8] = mode_q[0];
                mode_d       = PRIV_S;
            end else begin
                tvec             = mtvec_q;
                mepc_d           = epc & ~32'h3;
                mcause_d         = {is_int, 27'b0, code};
                mtval_d          = '0;
                mstatus_d[7]     = mstatus_q[3];
                mstatus_d[3]     = 1'b0;
                mstatus_d[12:11] = mode_q;
                mode_d           = PRIV_M;
            end
            trap_vec = (tvec & ~32'h3) +
                       ((is_int && tvec[1:0] == 2'b01) ? {26'b0, code, 2'b00} : 32'h0);
        end
    end

    // Reads see the post-commit (_d) state, which forwards a same-cycle stage-B write
    always_comb begin
        rd = '0;
        case (input_csr_addr)
            12'hC00: rd = reg_cycle[31:0];
            12'hC01: rd = reg_time[31:0];
            12'hC80: rd = reg_cycle[63:32];
            12'hC81: rd = reg_time[63:32];
            12'hF14: rd = 32'(HART_ID);
            12'h300: rd = mstatus_d;
            12'h301: rd = MISA_VAL;
            12'h302: rd = medeleg_d;
            12'h303: rd = mideleg_d;
            12'h304: rd = mie_d;
            12'h305: rd = mtvec_d;
            12'h340: rd = mscratch_d;
            12'h341: rd = mepc_d;
            12'h342: rd = mcause_d;
            12'h343: rd = mtval_d;
            12'h344: rd = mip_next;
            12'h100: rd = mstatus_d & SSTATUS_MASK;
            12'h104: rd = mie_d & mideleg_d;
            12'h105: rd = stvec_d;
            12'h140: rd = sscratch_d;
            12'h141: rd = sepc_d;
            12'h142: rd = scause_d;
            12'h143: rd = stval_d;
            12'h144: rd = mip_next & mideleg_d;
            default: rd = '0;
        endcase
        if (!SUPPORT_S && input_csr_addr[9:8] == 2'b01) rd = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= PRIV_M;    mstatus_q <= '0;   medeleg_q <= '0;  mideleg_q <= '0;
            mie_q <= '0;         sw_ip_q <= '0;     mtvec_q <= MTVEC_RESET;
            mscratch_q <= '0;    mepc_q <= '0;      mcause_q <= '0;   mtval_q <= '0;
            stvec_q <= MTVEC_RESET; sscratch_q <= '0; sepc_q <= '0;   scause_q <= '0;
            stval_q <= '0;
            b_valid_q <= 1'b0;   b_cmd_q <= CSR_X;  b_addr_q <= '0;   b_op1_q <= '0;
            b_pc_q <= '0;        rdata_q <= '0;     out_valid_q <= 1'b0;
            trap_valid_q <= 1'b0; trap_vector_q <= '0;
        end else begin
            mode_q <= mode_d;    mstatus_q <= mstatus_d; medeleg_q <= medeleg_d;
            mideleg_q <= mideleg_d; mie_q <= mie_d; sw_ip_q <= sw_ip_d; mtvec_q <= mtvec_d;
            mscratch_q <= mscratch_d; mepc_q <= mepc_d; mcause_q <= mcause_d;
            mtval_q <= mtval_d;  stvec_q <= stvec_d; sscratch_q <= sscratch_d;
            sepc_q <= sepc_d;    scause_q <= scause_d; stval_q <= stval_d;
            b_valid_q   <= accept;
            out_valid_q <= accept;
            if (accept) begin
                b_cmd_q  <= input_csr_cmd;
                b_addr_q <= input_csr_addr;
                b_op1_q  <= input_op1_data;
                b_pc_q   <= input_pc;
                rdata_q  <= rd;
            end
            trap_valid_q  <= trap_take;
            trap_vector_q <= trap_vec;
        end
    end

    assign output_valid = out_valid_q;
    assign csr_rdata    = rdata_q;
    assign trap_valid   = trap_valid_q;
    assign trap_vector  = trap_vector_q;
    assign output_mode  = mode_q;

endmodule

// File: tb/tb_csr_unit_ms.sv
// Directed bench for csr_unit_ms: read data checked through a scoreboard queue,
// trap redirects and privilege mode checked at each step.
module tb_csr_unit_ms;

    localparam logic [2:0] CSR_W = 3'd1, CSR_S = 3'd2;
    localparam logic [2:0] CSR_ECALL = 3'd4, CSR_MRET = 3'd5, CSR_SRET = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] reg_cycle, reg_time, reg_mtime, reg_mtimecmp;
    logic        irq_ext, irq_soft, wb_branch_hazard, input_valid;
    logic [2:0]  input_csr_cmd;
    logic [11:0] input_csr_addr;
    logic [31:0] input_op1_data, input_pc;
    logic        input_interrupt_ready;
    logic        output_valid, trap_valid, output_stall_flg_may_interrupt;
    logic [31:0] csr_rdata, trap_vector;
    logic [1:0]  output_mode;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    csr_unit_ms #(
        .MTVEC_RESET(32'h0000_0080),
        .HART_ID    (5),
        .SUPPORT_S  (1'b1),
        .VECTORED   (1'b1)
    ) dut (
        .clk                           (clk),
        .reset                         (reset),
        .reg_cycle                     (reg_cycle),
        .reg_time                      (reg_time),
        .reg_mtime                     (reg_mtime),
        .reg_mtimecmp                  (reg_mtimecmp),
        .irq_ext                       (irq_ext),
        .irq_soft                      (irq_soft),
        .wb_branch_hazard              (wb_branch_hazard),
        .input_valid                   (input_valid),
        .input_csr_cmd                 (input_csr_cmd),
        .input_csr_addr                (input_csr_addr),
        .input_op1_data                (input_op1_data),
        .input_pc                      (input_pc),
        .input_interrupt_ready         (input_interrupt_ready),
        .output_valid                  (output_valid),
        .csr_rdata                     (csr_rdata),
        .trap_valid                    (trap_valid),
        .trap_vector                   (trap_vector),
        .output_mode                   (output_mode),
        .output_stall_flg_may_interrupt(output_stall_flg_may_interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One-cycle command; the old CSR value it should return goes to the scoreboard
    task automatic issue(input logic [2:0] cmd, input logic [11:0] addr, input logic [31:0] op1,
                         input logic [31:0] pc, input logic [31:0] exp, input string tag);
        input_valid    = 1'b1;
        input_csr_cmd  = cmd;
        input_csr_addr = addr;
        input_op1_data = op1;
        input_pc       = pc;
        sb.push_back('{tag, exp});
        @(posedge clk); #1;
        input_valid = 1'b0;
    endtask

    task automatic wait_trap(input string tag, input logic [31:0] vec, input logic [1:0] mode);
        int n = 0;
        @(negedge clk);
        while (!trap_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, 32'(trap_valid), 32'h1);
        chk({tag, "_vec"}, trap_vector, vec);
        chk({tag, "_mode"}, 32'(output_mode), 32'(mode));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(trap_valid), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic expect_no_trap(input string tag);
        int seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (trap_valid) seen++;
        end
        chk(tag, seen, 0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!reset && output_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(output_valid), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk(mon_e.tag, csr_rdata, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        reg_cycle = 64'h1; reg_time = 64'h2; reg_mtime = 64'd10; reg_mtimecmp = 64'd5;
        irq_ext = 1'b0; irq_soft = 1'b0; wb_branch_hazard = 1'b0; input_valid = 1'b0;
        input_csr_cmd = '0; input_csr_addr = '0; input_op1_data = '0; input_pc = '0;
        input_interrupt_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mode", 32'(output_mode), 32'h3);
        chk("rst_trap_valid", 32'(trap_valid), 32'h0);
        chk("rst_rdata", csr_rdata, 32'h0);
        chk("rst_out_valid", 32'(output_valid), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // mtvec reset value, write, then back-to-back forwarded set
        issue(CSR_S, 12'h305, 32'h0,   32'h0, 32'h80,  "mtvec_rst");
        issue(CSR_W, 12'h305, 32'h100, 32'h0, 32'h80,  "mtvec_w");
        issue(CSR_S, 12'h305, 32'h1,   32'h0, 32'h100, "mtvec_fwd");
        issue(CSR_S, 12'h305, 32'h0,   32'h0, 32'h101, "mtvec_final");
        issue(CSR_W, 12'h105, 32'h500, 32'h0, 32'h80,  "stvec_w");

        // Machine timer interrupt, vectored
        issue(CSR_W, 12'h304, 32'h80,  32'h0, 32'h0,   "mie_w");
        issue(CSR_W, 12'h300, 32'h8,   32'h0, 32'h0,   "mstatus_w");
        drain();
        @(negedge clk);
        chk("may_int_tmr", 32'(output_stall_flg_may_interrupt), 32'h1);
        @(posedge clk); #1;
        input_pc = 32'h40;
        input_interrupt_ready = 1'b1;
        wait_trap("tmr", 32'h11C, 2'd3);
        input_interrupt_ready = 1'b0;
        @(negedge clk);
        chk("may_int_masked", 32'(output_stall_flg_may_interrupt), 32'h0);
        @(posedge clk); #1;
        issue(CSR_S, 12'h342, 32'h0, 32'h0, 32'h8000_0007, "mcause_tmr");
        issue(CSR_S, 12'h341, 32'h0, 32'h0, 32'h40,        "mepc_tmr");
        issue(CSR_S, 12'h300, 32'h0, 32'h0, 32'h1880,      "mstatus_tmr");
        issue(CSR_W, 12'h304, 32'h0, 32'h0, 32'h80,        "mie_clr");

        // MRET to U, then delegated ECALL from U to S
        issue(CSR_W, 12'h302, 32'h100, 32'h0, 32'h0,    "medeleg_w");
        issue(CSR_W, 12'h341, 32'h300, 32'h0, 32'h40,   "mepc_w");
        issue(CSR_W, 12'h300, 32'h80,  32'h0, 32'h1880, "mstatus_mpp0");
        issue(CSR_MRET, 12'h000, 32'h0, 32'h0, 32'h0,   "mret_cmd");
        wait_trap("mret", 32'h300, 2'd0);
        issue(CSR_S, 12'h300, 32'h0, 32'h0, 32'h88, "mstatus_mret");
        issue(CSR_ECALL, 12'h000, 32'h0, 32'h200, 32'h0, "ecall_u_cmd");
        wait_trap("ecall_u", 32'h500, 2'd1);
        issue(CSR_S, 12'h142, 32'h0, 32'h0, 32'h8,   "scause");
        issue(CSR_S, 12'h141, 32'h0, 32'h0, 32'h200, "sepc");
        issue(CSR_S, 12'h300, 32'h0, 32'h0, 32'h88,  "mstatus_ecall_s");

        // SRET back to U; xRET from U must be ignored
        issue(CSR_SRET, 12'h000, 32'h0, 32'h0, 32'h0, "sret_cmd");
        wait_trap("sret", 32'h200, 2'd0);
        issue(CSR_SRET, 12'h000, 32'h0, 32'h0, 32'h0, "sret_u_cmd");
        expect_no_trap("sret_u_nop");
        issue(CSR_MRET, 12'h000, 32'h0, 32'h0, 32'h0, "mret_u_cmd");
        expect_no_trap("mret_u_nop");
        @(negedge clk);
        chk("mode_still_u", 32'(output_mode), 32'h0);
        @(posedge clk); #1;

        // Undelegated ECALL from U lands in M at the non-vectored base
        issue(CSR_W, 12'h302, 32'h0, 32'h0, 32'h100, "medeleg_clr");
        issue(CSR_ECALL, 12'h000, 32'h0, 32'h600, 32'h0, "ecall_m_cmd");
        wait_trap("ecall_m", 32'h100, 2'd3);
        issue(CSR_S, 12'h342, 32'h0, 32'h0, 32'h8,  "mcause_ecall");
        issue(CSR_S, 12'h300, 32'h8, 32'h0, 32'hA0, "mstatus_ecall_m");

        // External and timer both pending: external wins
        issue(CSR_W, 12'h304, 32'h880, 32'h0, 32'h0, "mie_ext");
        irq_ext = 1'b1;
        drain();
        input_pc = 32'h44;
        input_interrupt_ready = 1'b1;
        wait_trap("ext", 32'h12C, 2'd3);
        input_interrupt_ready = 1'b0;
        irq_ext = 1'b0;
        issue(CSR_S, 12'h342, 32'h0, 32'h0, 32'h8000_000B, "mcause_ext");
        issue(CSR_S, 12'h341, 32'h0, 32'h0, 32'h44,        "mepc_ext");
        issue(CSR_W, 12'h304, 32'h0, 32'h0, 32'h880,       "mie_clr2");
        issue(CSR_S, 12'h344, 32'h0, 32'h0, 32'h80,        "mip_rd");

        // Read-only and unimplemented addresses
        issue(CSR_W, 12'hF14, 32'h1234, 32'h0, 32'h5, "mhartid_w");
        issue(CSR_S, 12'hF14, 32'h0,    32'h0, 32'h5, "mhartid_rd");
        issue(CSR_S, 12'h7C0, 32'h0,    32'h0, 32'h0, "unimpl_rd");

        // Flushed command is dropped while the stage-B write still lands
        issue(CSR_W, 12'h340, 32'h55, 32'h0, 32'h0, "mscratch_w");
        input_valid = 1'b1;
        wb_branch_hazard = 1'b1;
        input_csr_cmd = CSR_W;
        input_csr_addr = 12'h340;
        input_op1_data = 32'hAA;
        @(posedge clk); #1;
        input_valid = 1'b0;
        wb_branch_hazard = 1'b0;
        @(negedge clk);
        chk("flush_drop", 32'(output_valid), 32'h0);
        @(posedge clk); #1;
        issue(CSR_S, 12'h340, 32'h0, 32'h0, 32'h55, "mscratch_rd");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
